demorgan_checker: RTL and testbench

DEMORGAN_CHECKER -- requirements
Module: demorgan_checker

---
 rtl/demorgan_checker.sv | 149 ++++++++++++++
 tb/tb_demorgan_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/demorgan_checker.sv
// demorgan_checker: sweeps every (a, b) operand pair of WIDTH bits, computes
// both sides of a selected De Morgan identity, registers them and counts the
// patterns where the two sides disagree.
//
// Optional build macro DEMORGAN_FAULT_INJ_EN adds input fault_en. When it is
// high, rhs bit 0 is inverted for the last pattern of each sweep, so a sweep
// ends with exactly one mismatch.
module demorgan_checker #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 law_sel,
`ifdef DEMORGAN_FAULT_INJ_EN
  input  logic                 fault_en,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_cnt,
  output logic [WIDTH-1:0]     cur_a,
  output logic [WIDTH-1:0]     cur_b,
  output logic [WIDTH-1:0]     lhs,
  output logic [WIDTH-1:0]     rhs
);

  localparam int CW = 2 * WIDTH;   // pattern counter width
  localparam int EW = CW + 1;      // error counter width, holds up to 2^CW

  localparam logic [CW-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            law_q;
  logic [EW-1:0]   err_q;
  logic [EW-1:0]   err_d;
  logic            pass_q;
  logic [WIDTH-1:0] lhs_q, rhs_q;
  logic [WIDTH-1:0] lhs_d, rhs_d;
  logic [WIDTH-1:0] op_a, op_b;
  logic            mismatch;

  assign op_a = cnt_q[CW-1:WIDTH];
  assign op_b = cnt_q[WIDTH-1:0];

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Both sides of the selected identity for the pattern in flight, plus the
  // optional deliberate corruption of the last pattern.
  always_comb begin
    if (law_q) begin
      lhs_d = ~(op_a & op_b);
      rhs_d = ~op_a | ~op_b;
    end else begin
      lhs_d = ~(op_a | op_b);
      rhs_d = ~op_a & ~op_b;
    end
`ifdef DEMORGAN_FAULT_INJ_EN
    if (fault_en && (cnt_q == CNT_LAST)) rhs_d[0] = ~rhs_d[0];
`endif
  end

  // Comparison of the registered results; only counted while a sweep is live.
  always_comb begin
    mismatch = ((state_q == RUN) || (state_q == DRAIN)) && (lhs_q != rhs_q);
    err_d    = mismatch ? err_q + EW'(1) : err_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Sweep datapath: pattern counter, captured law, error count and verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      law_q  <= 1'b0;
      err_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q  <= '0;
            law_q  <= law_sel;
            err_q  <= '0;
            pass_q <= 1'b0;
          end
        end
        RUN: begin
          // Natural wrap from CNT_LAST back to zero as the sweep ends.
          cnt_q <= cnt_q + CW'(1);
          err_q <= err_d;
        end
        DRAIN: begin
          // Last comparison lands here, so the verdict uses the updated count.
          err_q  <= err_d;
          pass_q <= (err_d == '0);
        end
        default: ;
      endcase
    end
  end

  // Result pipeline: one-cycle registered copy of both identity sides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhs_q <= '0;
      rhs_q <= '0;
    end else begin
      lhs_q <= lhs_d;
      rhs_q <= rhs_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign cur_a   = op_a;
  assign cur_b   = op_b;
  assign lhs     = lhs_q;
  assign rhs     = rhs_q;

endmodule

// File: tb/tb_demorgan_checker.sv
// Directed bench for demorgan_checker: a WIDTH=2 instance for the sweep,
// probe, disturbance and reset sequences, and a WIDTH=1 instance for
// back-to-back sweeps with start held high.
module tb_demorgan_checker;

  logic clk;
  logic rst;

  // WIDTH=2 instance signals
  logic       start, law_sel, fault_en;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [1:0] cur_a, cur_b, lhs, rhs;

  // WIDTH=1 instance signals
  logic       start1, law_sel1, fault_en1;
  logic       busy1, done1, pass1;
  logic [2:0] err_cnt1;
  logic [0:0] cur_a1, cur_b1, lhs1, rhs1;

  int n_checks = 0;
  int n_errors = 0;

  demorgan_checker #(.WIDTH(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .law_sel(law_sel),
`ifdef DEMORGAN_FAULT_INJ_EN
    .fault_en(fault_en),
`endif
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .cur_a(cur_a), .cur_b(cur_b), .lhs(lhs), .rhs(rhs)
  );

  demorgan_checker #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .law_sel(law_sel1),
`ifdef DEMORGAN_FAULT_INJ_EN
    .fault_en(fault_en1),
`endif
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
    .cur_a(cur_a1), .cur_b(cur_b1), .lhs(lhs1), .rhs(rhs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One sweep on the WIDTH=2 instance. Sample index idx is the cycle after
  // posedge idx, counting from the edge that accepts start. cur_a/cur_b are
  // captured at idx == probe, lhs/rhs one cycle later.
  task automatic run_sweep(input logic law, input int probe, input bit disturb,
                           output int busy_n, output int done_n, output int done_idx,
                           output logic [1:0] ca, output logic [1:0] cb,
                           output logic [1:0] lo, output logic [1:0] ro,
                           output logic [4:0] err, output logic ps);
    busy_n = 0; done_n = 0; done_idx = -1;
    ca = 'x; cb = 'x; lo = 'x; ro = 'x; err = 'x; ps = 1'bx;
    @(negedge clk);
    start = 1'b1;
    law_sel = law;
    @(posedge clk);
    for (int idx = 0; idx < 60; idx++) begin
      @(negedge clk);
      if (idx == 0) start = 1'b0;
      if (disturb && idx == 3) begin start = 1'b1; law_sel = ~law; end
      if (disturb && idx == 5) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_idx < 0) done_idx = idx;
      end
      if (idx == probe) begin ca = cur_a; cb = cur_b; end
      if (idx == probe + 1) begin lo = lhs; ro = rhs; end
      if (done_idx >= 0 && idx > done_idx) begin
        err = err_cnt;
        ps  = pass;
        break;
      end
    end
  endtask

  typedef struct {
    logic       law;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] exp_lhs;
    logic [1:0] exp_rhs;
    bit         disturb;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int         bn, dn, di;
    logic [1:0] ca, cb, lo, ro;
    logic [4:0] er;
    logic       ps;
    int         pulses, last_done, gap_err, waited;
    bit         prev_done, prev2_done;

    // law, a, b, expected lhs, expected rhs, disturb during RUN
    vecs[0] = '{1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0};
    vecs[1] = '{1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
    vecs[2] = '{1'b0, 2'b10, 2'b00, 2'b01, 2'b01, 1'b0};
    vecs[3] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0};
    vecs[4] = '{1'b1, 2'b01, 2'b10, 2'b11, 2'b11, 1'b0};
    vecs[5] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0};
    vecs[6] = '{1'b1, 2'b10, 2'b11, 2'b01, 2'b01, 1'b0};
    vecs[7] = '{1'b1, 2'b00, 2'b01, 2'b11, 2'b11, 1'b0};
    // law 1 with start/law_sel toggling mid-run; law 0 would give 00 here.
    vecs[8] = '{1'b1, 2'b01, 2'b10, 2'b11, 2'b11, 1'b1};

    start = 0; law_sel = 0; fault_en = 0;
    start1 = 0; law_sel1 = 0; fault_en1 = 0;
    rst = 1'b1;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset err_cnt", err_cnt, 0);
    check("reset cur", {cur_a, cur_b}, 0);
    check("reset lhs/rhs", {lhs, rhs}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven sweeps: probe results and full-sweep timing/verdict.
    for (int i = 0; i < 9; i++) begin
      run_sweep(vecs[i].law, int'({vecs[i].a, vecs[i].b}), vecs[i].disturb,
                bn, dn, di, ca, cb, lo, ro, er, ps);
      check($sformatf("v%0d cur_a", i), ca, vecs[i].a);
      check($sformatf("v%0d cur_b", i), cb, vecs[i].b);
      check($sformatf("v%0d lhs", i), lo, vecs[i].exp_lhs);
      check($sformatf("v%0d rhs", i), ro, vecs[i].exp_rhs);
      check($sformatf("v%0d busy cycles", i), bn, 17);
      check($sformatf("v%0d done count", i), dn, 1);
      check($sformatf("v%0d done cycle", i), di, 17);
      check($sformatf("v%0d err_cnt", i), er, 0);
      check($sformatf("v%0d pass", i), ps, 1);
    end

    // Results hold in IDLE.
    repeat (3) @(negedge clk);
    check("idle hold pass", pass, 1);
    check("idle hold err_cnt", err_cnt, 0);
    check("idle busy", busy, 0);

    // Asynchronous reset mid-sweep at cnt = 5.
    @(negedge clk);
    start = 1'b1;
    law_sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!(cur_a == 2'b01 && cur_b == 2'b01) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("reached cnt=5", {cur_a, cur_b}, 4'b0101);
    check("busy before reset", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    check("mid reset pass", pass, 0);
    check("mid reset err_cnt", err_cnt, 0);
    check("mid reset cur", {cur_a, cur_b}, 0);
    check("mid reset lhs/rhs", {lhs, rhs}, 0);
    #1 rst = 1'b0;
    run_sweep(1'b0, 5, 1'b0, bn, dn, di, ca, cb, lo, ro, er, ps);
    check("post reset busy cycles", bn, 17);
    check("post reset done cycle", di, 17);
    check("post reset lhs", lo, 2'b10);
    check("post reset err_cnt", er, 0);
    check("post reset pass", ps, 1);

`ifdef DEMORGAN_FAULT_INJ_EN
    fault_en = 1'b1;
    run_sweep(1'b0, 0, 1'b0, bn, dn, di, ca, cb, lo, ro, er, ps);
    check("fault err_cnt", er, 1);
    check("fault pass", ps, 0);
    check("fault done cycle", di, 17);
    fault_en = 1'b0;
    run_sweep(1'b1, 0, 1'b0, bn, dn, di, ca, cb, lo, ro, er, ps);
    check("no fault err_cnt", er, 0);
    check("no fault pass", ps, 1);
`endif

    // WIDTH=1: start held high, sweeps every 7 cycles (5 busy, DONE, IDLE).
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    pulses = 0; last_done = -1; gap_err = 0;
    prev_done = 0; prev2_done = 0;
    for (int idx = 0; idx < 50; idx++) begin
      @(negedge clk);
      if (prev_done && (busy1 || done1)) gap_err++;
      if (prev2_done && !busy1) gap_err++;
      if (done1) begin
        pulses++;
        if (busy1) gap_err++;
        if (last_done >= 0 && idx - last_done != 7) gap_err++;
        if (last_done < 0 && idx != 5) gap_err++;
        last_done = idx;
      end
      prev2_done = prev_done;
      prev_done = done1;
    end
    check("w1 done pulses", pulses, 7);
    check("w1 sequence errors", gap_err, 0);
    start1 = 1'b0;
    waited = 0;
    while (!done1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("w1 final done seen", done1, 1);
    @(negedge clk);
    check("w1 final busy", busy1, 0);
    check("w1 err_cnt", err_cnt1, 0);
    check("w1 pass", pass1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
